// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver and SYNC/CMD/ARG/CHK command parser driving the analyzer trigger config.
// Optional inter-byte timeout inside a frame is enabled by defining UART_CMD_TIMEOUT_EN.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | half-bit wait to confirm the start bit
// RX_DATA  | sampling 8 data bits at bit centres
// RX_STOP  | sampling the stop bit
// P_SYNC   | waiting for 8'hA5
// P_CMD    | expecting opcode byte
// P_ARG    | expecting argument byte
// P_CHK    | expecting checksum byte, command executes here
module uart_cmd_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
`ifdef UART_CMD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 500_000
`endif
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rx,
  output logic [7:0] trigger_mask,
  output logic [7:0] edge_trigger,
  output logic [7:0] trigger_type,
  output logic [1:0] trigger_mode,
  output logic       cfg_changed,
  output logic       run_pulse,
  output logic       stop_pulse,
  output logic       resend_pulse,
  output logic       cmd_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] CMD_RUN    = 8'h01;
  localparam logic [7:0] CMD_STOP   = 8'h02;
  localparam logic [7:0] CMD_MODE   = 8'h03;
  localparam logic [7:0] CMD_CHCFG  = 8'h04;
  localparam logic [7:0] CMD_RESEND = 8'h05;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_SYNC, P_CMD, P_ARG, P_CHK} p_state_t;

  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          bit_cnt_d  = HALF_LOAD;
        end
      end
      RX_START: begin
        if (bit_cnt_q == '0) begin
          // A line back high at mid start bit is a glitch, not a byte.
          if (!rx_s2_q) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = BIT_LOAD;
            bit_idx_d  = '0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == '0) begin
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d = BIT_LOAD;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          if (rx_s2_q) byte_valid_d = 1'b1;
          else         frame_err_d  = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  p_state_t   p_state_q, p_state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] arg_q, arg_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] edge_q, edge_d;
  logic [7:0] type_q, type_d;
  logic [1:0] mode_q, mode_d;
  logic       cfg_q, cfg_d;
  logic       run_q, run_d;
  logic       stop_q, stop_d;
  logic       resend_q, resend_d;
  logic       err_q, err_d;
  logic       timeout;
  logic       cmd_ok;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                                to_cnt_q <= TO_LOAD;
    else if (p_state_q == P_SYNC || byte_valid_q)  to_cnt_q <= TO_LOAD;
    else if (to_cnt_q != '0)                       to_cnt_q <= to_cnt_q - 1'b1;
  end

  assign timeout = (p_state_q != P_SYNC) && (to_cnt_q == '0);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    cmd_ok = 1'b0;
    case (cmd_q)
      CMD_RUN, CMD_STOP, CMD_RESEND: cmd_ok = 1'b1;
      CMD_MODE:  cmd_ok = (arg_q[7:2] == 6'd0) && (arg_q[1:0] != 2'd3);
      CMD_CHCFG: cmd_ok = !arg_q[7] && !arg_q[3] &&
                          (arg_q[2:0] inside {3'b000, 3'b001, 3'b011, 3'b101, 3'b111});
      default:   cmd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      p_state_q <= P_SYNC;
      cmd_q     <= '0;
      arg_q     <= '0;
      mask_q    <= '0;
      edge_q    <= 8'hFF;
      type_q    <= '0;
      mode_q    <= '0;
      cfg_q     <= 1'b0;
      run_q     <= 1'b0;
      stop_q    <= 1'b0;
      resend_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      p_state_q <= p_state_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      type_q    <= type_d;
      mode_q    <= mode_d;
      cfg_q     <= cfg_d;
      run_q     <= run_d;
      stop_q    <= stop_d;
      resend_q  <= resend_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    p_state_d = p_state_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    mask_d    = mask_q;
    edge_d    = edge_q;
    type_d    = type_q;
    mode_d    = mode_q;
    cfg_d     = 1'b0;
    run_d     = 1'b0;
    stop_d    = 1'b0;
    resend_d  = 1'b0;
    err_d     = 1'b0;
    if (frame_err_q) begin
      p_state_d = P_SYNC;
      err_d     = 1'b1;
    end else if (timeout) begin
      // A byte landing on the timeout cycle starts the search for the next frame.
      err_d     = 1'b1;
      p_state_d = (byte_valid_q && shift_q == SYNC_BYTE) ? P_CMD : P_SYNC;
    end else if (byte_valid_q) begin
      case (p_state_q)
        P_SYNC: if (shift_q == SYNC_BYTE) p_state_d = P_CMD;
        P_CMD: begin
          cmd_d     = shift_q;
          p_state_d = P_ARG;
        end
        P_ARG: begin
          arg_d     = shift_q;
          p_state_d = P_CHK;
        end
        P_CHK: begin
          p_state_d = P_SYNC;
          if (shift_q != (cmd_q ^ arg_q) || !cmd_ok) begin
            err_d = 1'b1;
          end else begin
            case (cmd_q)
              CMD_RUN:    run_d    = 1'b1;
              CMD_STOP:   stop_d   = 1'b1;
              CMD_RESEND: resend_d = 1'b1;
              CMD_MODE: begin
                mode_d = arg_q[1:0];
                cfg_d  = 1'b1;
              end
              CMD_CHCFG: begin
                mask_d[arg_q[6:4]] = arg_q[0];
                type_d[arg_q[6:4]] = arg_q[1];
                edge_d[arg_q[6:4]] = ~arg_q[2];
                cfg_d              = 1'b1;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        default: p_state_d = P_SYNC;
      endcase
    end
  end

  assign trigger_mask = mask_q;
  assign edge_trigger = edge_q;
  assign trigger_type = type_q;
  assign trigger_mode = mode_q;
  assign cfg_changed  = cfg_q;
  assign run_pulse    = run_q;
  assign stop_pulse   = stop_q;
  assign resend_pulse = resend_q;
  assign cmd_err      = err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: bit-bangs 8N1 frames and checks config registers and pulse counts.
// Runs at 100 clocks per bit to keep the simulation short; timeout expectations follow UART_CMD_TIMEOUT_EN.
module tb_uart_cmd_rx;
  localparam int CLK_FREQ  = 50_000_000;
  localparam int BAUD_RATE = 500_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] trigger_mask, edge_trigger, trigger_type;
  logic [1:0] trigger_mode;
  logic       cfg_changed, run_pulse, stop_pulse, resend_pulse, cmd_err;

  always #5 sys_clk = ~sys_clk;

`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .TIMEOUT_CYCLES(5000)) dut (
`else
  uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
`endif
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rx(uart_rx),
    .trigger_mask(trigger_mask), .edge_trigger(edge_trigger), .trigger_type(trigger_type),
    .trigger_mode(trigger_mode), .cfg_changed(cfg_changed), .run_pulse(run_pulse),
    .stop_pulse(stop_pulse), .resend_pulse(resend_pulse), .cmd_err(cmd_err));

  int n_run = 0, n_stop = 0, n_res = 0, n_cfg = 0, n_err = 0;
  int b_run, b_stop, b_res, b_cfg, b_err;
  int tests = 0, fails = 0;

  always @(negedge sys_clk) begin
    if (run_pulse)    n_run++;
    if (stop_pulse)   n_stop++;
    if (resend_pulse) n_res++;
    if (cfg_changed)  n_cfg++;
    if (cmd_err)      n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_run = n_run; b_stop = n_stop; b_res = n_res; b_cfg = n_cfg; b_err = n_err;
  endtask

  task automatic deltas(input string tag, input int run, input int stp, input int res,
                        input int cfg, input int err);
    check({tag, " run"},    n_run  - b_run,  run);
    check({tag, " stop"},   n_stop - b_stop, stp);
    check({tag, " resend"}, n_res  - b_res,  res);
    check({tag, " cfg"},    n_cfg  - b_cfg,  cfg);
    check({tag, " err"},    n_err  - b_err,  err);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge sys_clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(posedge sys_clk);
    if (!stop_bit) begin
      uart_rx = 1'b1;
      repeat (CPB) @(posedge sys_clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send_byte(8'hA5, 1'b1);
    send_byte(c, 1'b1);
    send_byte(a, 1'b1);
    send_byte(k, 1'b1);
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic check_cfg(input string tag, input logic [7:0] m, input logic [7:0] e,
                           input logic [7:0] t, input logic [1:0] md);
    check({tag, " mask"}, trigger_mask, m);
    check({tag, " edge"}, edge_trigger, e);
    check({tag, " type"}, trigger_type, t);
    check({tag, " mode"}, trigger_mode, md);
  endtask

  initial begin
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    check_cfg("reset", 8'h00, 8'hFF, 8'h00, 2'd0);
    check("reset pulses", {cfg_changed, run_pulse, stop_pulse, resend_pulse, cmd_err}, 5'b0);
    sys_rst_n = 1'b1;
    repeat (20) @(posedge sys_clk);

    snap(); send_frame(8'h04, 8'h31, 8'h35);
    check_cfg("ch3 code1", 8'h08, 8'hFF, 8'h00, 2'd0);
    deltas("ch3 code1", 0, 0, 0, 1, 0);

    snap(); send_frame(8'h04, 8'h37, 8'h33);
    check_cfg("ch3 code7", 8'h08, 8'hF7, 8'h08, 2'd0);
    deltas("ch3 code7", 0, 0, 0, 1, 0);

    snap(); send_frame(8'h03, 8'h02, 8'h01);
    check("mode2", trigger_mode, 2'd2);
    deltas("mode2", 0, 0, 0, 1, 0);

    snap(); send_frame(8'h03, 8'h03, 8'h00);
    check("mode3 rejected", trigger_mode, 2'd2);
    deltas("mode3", 0, 0, 0, 0, 1);

    snap();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_frame(8'h01, 8'h00, 8'h01);
    deltas("run after junk", 1, 0, 0, 0, 0);

    snap(); send_frame(8'h01, 8'h00, 8'h00);
    deltas("bad chk", 0, 0, 0, 0, 1);

    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (5) @(posedge sys_clk);
    deltas("framing", 0, 0, 0, 0, 1);
    snap(); send_frame(8'h02, 8'h00, 8'h02);
    deltas("stop after framing", 0, 1, 0, 0, 0);

    snap(); send_frame(8'h05, 8'h00, 8'h05);
    deltas("resend", 0, 0, 1, 0, 0);

    snap(); send_frame(8'h04, 8'h32, 8'h36);
    check_cfg("bad code", 8'h08, 8'hF7, 8'h08, 2'd2);
    deltas("bad code", 0, 0, 0, 0, 1);

    snap(); send_frame(8'h06, 8'h00, 8'h06);
    deltas("bad opcode", 0, 0, 0, 0, 1);

    snap();
    uart_rx = 1'b0;
    repeat (30) @(posedge sys_clk);
    uart_rx = 1'b1;
    repeat (300) @(posedge sys_clk);
    deltas("glitch", 0, 0, 0, 0, 0);
    snap(); send_frame(8'h05, 8'h00, 8'h05);
    deltas("resend after glitch", 0, 0, 1, 0, 0);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge sys_clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    check_cfg("mid-frame reset", 8'h00, 8'hFF, 8'h00, 2'd0);
    sys_rst_n = 1'b1;
    repeat (3 * CPB) @(posedge sys_clk);
    snap(); send_frame(8'h04, 8'h71, 8'h75);
    check_cfg("ch7 after reset", 8'h80, 8'hFF, 8'h00, 2'd0);
    deltas("ch7 after reset", 0, 0, 0, 1, 0);

    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (6000) @(posedge sys_clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
`ifdef UART_CMD_TIMEOUT_EN
    deltas("gap timeout", 0, 0, 0, 0, 1);
`else
    deltas("gap no timeout", 1, 0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
